// File: rtl/hc595_frame_arbiter.sv
// Round-robin arbiter that shares one 74HC595 chain between N_REQ frame sources.
// Serializes the granted word MSB-first with a divided shift clock, then pulses the latch.
module hc595_frame_arbiter #(
    parameter int N_REQ   = 2,
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int IDW     = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        ack,
    output logic                    busy,
    output logic                    done,
    output logic [IDW-1:0]          done_id,
    output logic                    sr_data,
    output logic                    sr_clk,
    output logic                    sr_latch
);
    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("CLK_DIV must be at least 1");
    end

    localparam int CNT_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_LATCH, ST_DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                phase_q, phase_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [IDW-1:0]      ptr_q, ptr_d;
    logic [IDW-1:0]      gid_q, gid_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [IDW-1:0]      done_id_q, done_id_d;
    logic                sr_data_q, sr_data_d;
    logic                sr_clk_q, sr_clk_d;
    logic                sr_latch_q, sr_latch_d;

    // Outputs are registered, so each one shows the decision of the previous cycle.
    always_comb begin
        int   cand;
        int   sel;
        logic found;
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        phase_d    = phase_q;
        shreg_d    = shreg_q;
        ptr_d      = ptr_q;
        gid_d      = gid_q;
        ack_d      = '0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        done_id_d  = '0;
        sr_data_d  = 1'b0;
        sr_clk_d   = 1'b0;
        sr_latch_d = 1'b0;
        found      = 1'b0;
        sel        = 0;
        cand       = 0;

        // Scan downward so the last hit is the closest one at or after the pointer.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = (int'(ptr_q) + i) % N_REQ;
            if (req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    ack_d     = N_REQ'(1) << sel;
                    busy_d    = 1'b1;
                    shreg_d   = req_data[sel*DATA_W +: DATA_W];
                    ptr_d     = IDW'((sel + 1) % N_REQ);
                    gid_d     = IDW'(sel);
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    phase_d   = 1'b0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy_d    = 1'b1;
                sr_data_d = shreg_q[DATA_W-1];
                sr_clk_d  = phase_q;
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    phase_d   = ~phase_q;
                    if (phase_q) begin
                        shreg_d = shreg_q << 1;
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = ST_LATCH;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            ST_LATCH: begin
                busy_d     = 1'b1;
                sr_latch_d = 1'b1;
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    state_d   = ST_DONE;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                busy_d    = 1'b1;
                done_d    = 1'b1;
                done_id_d = gid_q;
                div_cnt_d = '0;
                bit_cnt_d = '0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            phase_q    <= 1'b0;
            shreg_q    <= '0;
            ptr_q      <= '0;
            gid_q      <= '0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            done_id_q  <= '0;
            sr_data_q  <= 1'b0;
            sr_clk_q   <= 1'b0;
            sr_latch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            phase_q    <= phase_d;
            shreg_q    <= shreg_d;
            ptr_q      <= ptr_d;
            gid_q      <= gid_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            done_id_q  <= done_id_d;
            sr_data_q  <= sr_data_d;
            sr_clk_q   <= sr_clk_d;
            sr_latch_q <= sr_latch_d;
        end
    end

    assign ack      = ack_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign done_id  = done_id_q;
    assign sr_data  = sr_data_q;
    assign sr_clk   = sr_clk_q;
    assign sr_latch = sr_latch_q;

endmodule

// File: tb/tb_hc595_frame_arbiter.sv
// Directed bench for hc595_frame_arbiter with N_REQ=2, DATA_W=8, CLK_DIV=2.
// Frame timing: ack at cycle 0, latch at 33-34, done at 35, back-to-back period 36.
module tb_hc595_frame_arbiter;
    localparam int N  = 2;
    localparam int DW = 8;
    localparam int CD = 2;
    localparam int IW = 1;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    ack;
    logic            busy;
    logic            done;
    logic [IW-1:0]   done_id;
    logic            sr_data;
    logic            sr_clk;
    logic            sr_latch;

    int n_cmp = 0;
    int n_err = 0;

    hc595_frame_arbiter #(
        .N_REQ  (N),
        .DATA_W (DW),
        .CLK_DIV(CD),
        .IDW    (IW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .req_data(req_data),
        .ack     (ack),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .sr_data (sr_data),
        .sr_clk  (sr_clk),
        .sr_latch(sr_latch)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns at the negedge where ack is seen, or with a=0 after lim cycles.
    task automatic wait_ack(input int lim, output logic [N-1:0] a, output int n);
        a = '0;
        n = 0;
        while (n < lim && a == '0) begin
            @(negedge clk);
            n++;
            a = ack;
        end
    endtask

    // Called at the negedge of the ack cycle; watches cycles 1..35 of the frame.
    // pulse is ORed onto req at cycle 10 and removed at cycle 20.
    task automatic check_frame(input string tag, input int exp_id,
                               input logic [DW-1:0] exp_word, input logic [N-1:0] pulse);
        logic [DW-1:0] got;
        logic          prev_clk;
        int nrise, lat_first, lat_cnt, done_cyc, did, busy_low;
        got = '0; prev_clk = 1'b0; nrise = 0; lat_first = -1; lat_cnt = 0;
        done_cyc = -1; did = -1; busy_low = 0;
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            if (sr_clk && !prev_clk) begin
                got = {got[DW-2:0], sr_data};
                nrise++;
            end
            prev_clk = sr_clk;
            if (sr_latch) begin
                if (lat_first < 0) lat_first = c;
                lat_cnt++;
            end
            if (done) begin
                done_cyc = c;
                did = int'(done_id);
            end
            if (!busy) busy_low++;
            if (c == 10) req = req | pulse;
            if (c == 20) req = req & ~pulse;
        end
        check_eq({tag, "_rises"}, nrise, 8);
        check_eq({tag, "_word"}, got, exp_word);
        check_eq({tag, "_latch_first"}, lat_first, 33);
        check_eq({tag, "_latch_len"}, lat_cnt, 2);
        check_eq({tag, "_done_cyc"}, done_cyc, 35);
        check_eq({tag, "_done_id"}, did, exp_id);
        check_eq({tag, "_busy_held"}, busy_low, 0);
    endtask

    task automatic do_reset();
        req      = '0;
        req_data = '0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", {ack, busy, done, done_id, sr_data, sr_clk, sr_latch}, 0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    logic [N-1:0] a;
    int           n;
    int           bad;

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        req_data = '0;
        @(negedge clk);
        do_reset();

        // 1: single frame 0xA5 from requester 0
        req_data[7:0] = 8'hA5;
        req = 2'b01;
        wait_ack(10, a, n);
        check_eq("t1_ack", a, 2'b01);
        check_eq("t1_ack_lat", n, 1);
        req = 2'b00;
        check_frame("t1", 0, 8'hA5, 2'b00);
        @(negedge clk);
        check_eq("t1_idle_after", {busy, ack}, 0);

        // 2: both held, alternating grants at a 36-cycle period
        do_reset();
        req_data = {8'hF0, 8'h0F};
        req = 2'b11;
        wait_ack(10, a, n);
        check_eq("t2_ack0", a, 2'b01);
        check_frame("t2_f0", 0, 8'h0F, 2'b00);
        wait_ack(10, a, n);
        check_eq("t2_ack1", a, 2'b10);
        check_eq("t2_period1", n, 1);
        check_frame("t2_f1", 1, 8'hF0, 2'b00);
        wait_ack(10, a, n);
        check_eq("t2_ack2", a, 2'b01);
        check_eq("t2_period2", n, 1);
        check_frame("t2_f2", 0, 8'h0F, 2'b00);
        wait_ack(10, a, n);
        check_eq("t2_ack3", a, 2'b10);
        req = 2'b00;
        check_frame("t2_f3", 1, 8'hF0, 2'b00);

        // 3: req1 alone, then both -> pointer wraps to 0, then 1
        req_data = {8'h81, 8'h7E};
        req = 2'b10;
        wait_ack(10, a, n);
        check_eq("t3_ack_a", a, 2'b10);
        req = 2'b11;
        check_frame("t3_fa", 1, 8'h81, 2'b00);
        wait_ack(10, a, n);
        check_eq("t3_ack_b", a, 2'b01);
        req = 2'b10;
        check_frame("t3_fb", 0, 8'h7E, 2'b00);
        wait_ack(10, a, n);
        check_eq("t3_ack_c", a, 2'b10);
        req = 2'b00;
        check_frame("t3_fc", 1, 8'h81, 2'b00);

        // 4: req0 pulsed only while busy is never granted
        req_data = {8'h55, 8'hC3};
        req = 2'b10;
        wait_ack(10, a, n);
        check_eq("t4_ack_busy", a, 2'b10);
        req = 2'b00;
        check_frame("t4_f", 1, 8'h55, 2'b01);
        wait_ack(50, a, n);
        check_eq("t4_no_ack", a, 2'b00);
        req = 2'b01;
        wait_ack(10, a, n);
        check_eq("t4_ack_idle", a, 2'b01);
        check_eq("t4_ack_lat", n, 1);
        req = 2'b00;
        check_frame("t4_g", 0, 8'hC3, 2'b00);

        // 5: data changed after ack does not alter the frame in flight
        req_data[7:0] = 8'h3C;
        req = 2'b01;
        wait_ack(10, a, n);
        check_eq("t5_ack", a, 2'b01);
        req = 2'b00;
        req_data[7:0] = 8'hFF;
        check_frame("t5", 0, 8'h3C, 2'b00);

        // 6: async reset during bit 4 abandons the frame and clears the pointer
        req_data[7:0] = 8'h96;
        req = 2'b01;
        wait_ack(10, a, n);
        check_eq("t6_ack", a, 2'b01);
        req = 2'b00;
        repeat (18) @(negedge clk);
        check_eq("t6_busy_mid", busy, 1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_clear", {ack, busy, done, done_id, sr_data, sr_clk, sr_latch}, 0);
        bad = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (c == 3) rst_n = 1'b1;
            if (sr_latch || done || busy || sr_clk) bad++;
        end
        check_eq("t6_no_latch", bad, 0);
        req_data = {8'hE1, 8'h1E};
        req = 2'b11;
        wait_ack(10, a, n);
        check_eq("t6_ptr_zero", a, 2'b01);
        req = 2'b00;
        check_frame("t6_fa", 0, 8'h1E, 2'b00);
        req = 2'b10;
        wait_ack(10, a, n);
        check_eq("t6_req1_only", a, 2'b10);
        req = 2'b00;
        check_frame("t6_fb", 1, 8'hE1, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
